multicycle_divider: RTL and testbench
=====================================

# multicycle_divider

Parametrised iterative integer divider for the MIPS32 execute stage, the successor to the fixed 32-bit, one-bit-per-cycle HILO divider. It accepts signed or unsigned operands of configurable width and retires one or more quotient bits per cycle. It reports completion with a one-cycle `done` pulse and supports abort on pipeline flush. Divide-by-zero is detected and flagged in a single cycle. The ALU writes `{remainder, quotient}` into HILO on `done` and uses `busy` to stall HILO accesses.

## Interface
- `WIDTH`, 32: operand and result width; even, ≥ 4.
- `BITS_PER_CYCLE`, 1: quotient bits retired per cycle; 1 or 2; `WIDTH % BITS_PER_CYCLE == 0`.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands; sampled with `start`.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `abort`  in  1  cancel any operation in progress (EX flush).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results valid and updated.
- `quotient`  out  WIDTH  registered quotient; holds until next completion.
- `remainder`  out  WIDTH  registered remainder; holds until next completion.
- `div_by_zero`  out  1  registered; set on completion of a zero-divisor operation.

## Operation
- **States:** IDLE, CALC, FIXUP. Let K = WIDTH / BITS_PER_CYCLE. The step counter is ceil(log2(K+1)) bits wide.
- **IDLE, `start`=1, `abort`=0, divisor ≠ 0:**
  - Latch the operand magnitudes: absolute values if `is_signed`, raw otherwise.
  - Latch the sign of the quotient (dividend sign XOR divisor sign) and the sign of the remainder (dividend sign). Both are 0 when unsigned.
  - Set counter = K and go to CALC.
- **IDLE, `start`=1, divisor = 0:**
  - Go directly to FIXUP with the zero-divide marker set.
- **CALC:**
  - Each cycle performs BITS_PER_CYCLE restoring steps: shift the partial remainder left one bit, bringing in the next dividend MSB; trial-subtract the divisor magnitude (WIDTH+1-bit subtractor); if the result is non-negative, keep it and shift in a quotient bit of 1, otherwise shift in 0.
  - Decrement the counter. Go to FIXUP on the cycle the counter goes 1→0.
- **FIXUP (normal completion):**
  - `quotient` = negated magnitude if the quotient sign is set, otherwise the magnitude. `remainder` likewise, using the remainder sign.
  - `div_by_zero` ← 0, `done` ← 1, go to IDLE.
- **FIXUP (zero divide):**
  - `quotient` ← all ones, `remainder` ← raw dividend, `div_by_zero` ← 1, `done` ← 1, go to IDLE.
- **Signed MIN / −1:** the natural wrap applies: quotient = MIN, remainder = 0, no flag.
- **`busy`** = (state ≠ IDLE).
- **`start` while busy** is ignored; no queueing.
- **`abort` in CALC or FIXUP:** go to IDLE at the next edge. No `done` pulse. `quotient`, `remainder` and `div_by_zero` keep their previous values.
- **`abort` in IDLE:** overrides `start`, so the operation is not accepted.
- **Reset:** state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter=0. Reset asserted mid-operation discards the operation immediately and asynchronously.

## Timing
- Edge E0 samples `start`; `busy` is high from E0.
- Normal operation: CALC occupies edges E1..EK and FIXUP completes at EK+1.
  - `done` is high for exactly the cycle after EK+1, and `busy` falls at EK+1.
  - Latency is K+1 edges: 33 for WIDTH=32 with BITS_PER_CYCLE=1, and 17 with BITS_PER_CYCLE=2.
- Zero divide: FIXUP at E1, `done` high after E1 (latency 1).
- A new `start` is accepted in the cycle `done` is high, giving back-to-back throughput of one operation per K+1 cycles.
- Operand inputs may change freely after E0.
- `done` and `busy` are never high in the same cycle.

## Test plan
- WIDTH=32, BPC=1, unsigned 100 / 7 → `done` at E33, q=14, r=2, `div_by_zero`=0; `busy` high for 33 cycles.
- Signed −7 / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / −2 → q=0xFFFFFFFD, r=1. Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
- Unsigned 5 / 0 → `done` at E1, q=0xFFFFFFFF, r=5, `div_by_zero`=1. A following 9 / 3 clears the flag and gives q=3, r=0.
- Start 100 / 7, assert `abort` at E10 → `busy` low after E10, no `done`, q/r keep their old values. A new start of 0xFFFFFFFF / 16 (unsigned) → q=0x0FFFFFFF, r=15.
- WIDTH=16, BPC=2, unsigned 0xFFFF / 0x00FF → `done` at E9, q=0x0101, r=0. Back-to-back starts issued on the `done` cycles all complete correctly. `start` pulses while busy are ignored.
- Assert `reset` mid-CALC → all outputs 0 immediately and state IDLE. After release, 1 / 1 → q=1, r=0.

Source files
------------

// File: rtl/multicycle_divider_if.sv
// ---------------------------------------------------------------------------
// multicycle_divider_if
// Request/response bundle between the execute-stage ALU and the iterative
// divider.
//   master (ALU side)    : drives start, is_signed, dividend, divisor, abort;
//                          observes busy, done, quotient, remainder,
//                          div_by_zero.
//   slave  (divider side): the mirror image.
// Parameter WIDTH sets the operand/result width.
// ---------------------------------------------------------------------------
interface multicycle_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, abort,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, abort,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/multicycle_divider.sv
// ---------------------------------------------------------------------------
// multicycle_divider
// Iterative restoring integer divider (signed or unsigned) for the MIPS32
// execute stage. Retires BITS_PER_CYCLE quotient bits per clock, finishes
// with a sign fix-up cycle and pulses done for one cycle with the results.
// A zero divisor short-circuits straight to the fix-up cycle.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : multicycle_divider_if.slave (start/operands/abort in,
//           busy/done/quotient/remainder/div_by_zero out, all registered)
// Parameters:
//   WIDTH          : operand width, even and >= 4
//   BITS_PER_CYCLE : 1 or 2, must divide WIDTH
// ---------------------------------------------------------------------------
module multicycle_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    multicycle_divider_if.slave   bus
);
    localparam int K     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    // dvd_q holds the dividend magnitude; quotient bits shift in at its LSB
    // as dividend bits shift out of its MSB, so it ends up as the quotient.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             zero_div_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic             dd_neg_s;
    logic             ds_neg_s;
    logic [WIDTH-1:0] dd_abs_s;
    logic [WIDTH-1:0] ds_abs_s;

    // Operand conditioning: signs and magnitudes of the incoming operands.
    // The magnitude of MIN is 2^(WIDTH-1), which is exact as an unsigned value.
    always_comb begin
        dd_neg_s = bus.is_signed & bus.dividend[WIDTH-1];
        ds_neg_s = bus.is_signed & bus.divisor[WIDTH-1];
        if (dd_neg_s) begin
            dd_abs_s = -bus.dividend;
        end else begin
            dd_abs_s = bus.dividend;
        end
        if (ds_neg_s) begin
            ds_abs_s = -bus.divisor;
        end else begin
            ds_abs_s = bus.divisor;
        end
    end

    // Restoring step datapath: BITS_PER_CYCLE shift/trial-subtract steps.
    // The partial remainder stays below the divisor, so the shifted value is
    // below twice the divisor and a WIDTH+1-bit difference has a valid sign.
    always_comb begin
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        shift_s = '0;
        diff_s  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shift_s = {rem_d, dvd_d[WIDTH-1]};
            diff_s  = shift_s - {1'b0, dsr_q};
            if (diff_s[WIDTH] == 1'b0) begin
                rem_d = diff_s[WIDTH-1:0];
                dvd_d = {dvd_d[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shift_s[WIDTH-1:0];
                dvd_d = {dvd_d[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_div_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Keep the raw dividend: it becomes the remainder.
                            zero_div_q <= 1'b1;
                            dvd_q      <= bus.dividend;
                            cnt_q      <= '0;
                            state_q    <= S_FIXUP;
                        end else begin
                            zero_div_q <= 1'b0;
                            dvd_q      <= dd_abs_s;
                            dsr_q      <= ds_abs_s;
                            rem_q      <= '0;
                            q_neg_q    <= dd_neg_s ^ ds_neg_s;
                            r_neg_q    <= dd_neg_s;
                            cnt_q      <= CNT_W'(K);
                            state_q    <= S_CALC;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_FIXUP;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_FIXUP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (bus.abort) begin
                        done_q <= 1'b0;
                    end else if (zero_div_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dvd_q;
                        dz_q        <= 1'b1;
                        done_q      <= 1'b1;
                    end else begin
                        quotient_q  <= q_neg_q ? -dvd_q : dvd_q;
                        remainder_q <= r_neg_q ? -rem_q : rem_q;
                        dz_q        <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// ---------------------------------------------------------------------------
// tb_multicycle_divider
// Directed bench for multicycle_divider: a 32-bit 1-bit/cycle instance (A)
// and a 16-bit 2-bit/cycle instance (B) with hand-computed expected results,
// latencies, abort, divide-by-zero and asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_multicycle_divider;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    multicycle_divider_if #(.WIDTH(32)) a_if ();
    multicycle_divider_if #(.WIDTH(16)) b_if ();

    multicycle_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a_if)
    );

    multicycle_divider #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b_if)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One operation on instance A, launched on the current negedge.
    task automatic run_a(input logic sg, input logic [31:0] dd, input logic [31:0] ds,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input string tag);
        int lat;
        int bcnt;
        a_if.start     = 1'b1;
        a_if.is_signed = sg;
        a_if.dividend  = dd;
        a_if.divisor   = ds;
        @(negedge clock);
        a_if.start     = 1'b0;
        a_if.dividend  = 32'hDEAD_BEEF;
        a_if.divisor   = 32'h0000_0000;
        check_val({tag, ".busy_e0"}, 64'(a_if.busy), 64'd1);
        check_val({tag, ".done_e0"}, 64'(a_if.done), 64'd0);
        lat  = 0;
        bcnt = 0;
        while (!a_if.done && lat < 100) begin
            if (a_if.busy) bcnt++;
            @(negedge clock);
            lat++;
        end
        check_val({tag, ".lat"}, 64'(lat), 64'(elat));
        check_val({tag, ".busy_cycles"}, 64'(bcnt), 64'(elat));
        check_val({tag, ".busy_at_done"}, 64'(a_if.busy), 64'd0);
        check_val({tag, ".q"}, 64'(a_if.quotient), 64'(eq));
        check_val({tag, ".r"}, 64'(a_if.remainder), 64'(er));
        check_val({tag, ".dz"}, 64'(a_if.div_by_zero), 64'(edz));
    endtask

    // One operation on instance B; optionally pokes start while busy.
    task automatic run_b(input logic sg, input logic [15:0] dd, input logic [15:0] ds,
                         input logic [15:0] eq, input logic [15:0] er,
                         input int elat, input logic poke, input string tag);
        int lat;
        b_if.start     = 1'b1;
        b_if.is_signed = sg;
        b_if.dividend  = dd;
        b_if.divisor   = ds;
        @(negedge clock);
        b_if.start     = 1'b0;
        check_val({tag, ".busy_e0"}, 64'(b_if.busy), 64'd1);
        check_val({tag, ".done_e0"}, 64'(b_if.done), 64'd0);
        lat = 0;
        while (!b_if.done && lat < 100) begin
            if (poke && lat == 3) begin
                b_if.start    = 1'b1;
                b_if.dividend = 16'd5;
                b_if.divisor  = 16'd1;
            end else begin
                b_if.start = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        b_if.start = 1'b0;
        check_val({tag, ".lat"}, 64'(lat), 64'(elat));
        check_val({tag, ".busy_at_done"}, 64'(b_if.busy), 64'd0);
        check_val({tag, ".q"}, 64'(b_if.quotient), 64'(eq));
        check_val({tag, ".r"}, 64'(b_if.remainder), 64'(er));
        check_val({tag, ".dz"}, 64'(b_if.div_by_zero), 64'd0);
    endtask

    // Directed test sequence.
    initial begin
        logic seen_done;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a_if.start = 1'b0; a_if.is_signed = 1'b0; a_if.abort = 1'b0;
        a_if.dividend = 32'd0; a_if.divisor = 32'd0;
        b_if.start = 1'b0; b_if.is_signed = 1'b0; b_if.abort = 1'b0;
        b_if.dividend = 16'd0; b_if.divisor = 16'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst.busy", 64'(a_if.busy), 64'd0);
        check_val("rst.done", 64'(a_if.done), 64'd0);
        check_val("rst.q", 64'(a_if.quotient), 64'd0);
        check_val("rst.r", 64'(a_if.remainder), 64'd0);
        check_val("rst.dz", 64'(a_if.div_by_zero), 64'd0);

        // Instance A: unsigned and signed cases, issued back-to-back.
        run_a(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "u100_7");
        run_a(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "sm7_2");
        run_a(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, "s7_m2");
        run_a(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, "smin_m1");
        run_a(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, "dz5");
        run_a(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, "u9_3");
        check_val("u9_3.done_pulse", 64'(a_if.done), 64'd1);
        @(negedge clock);
        check_val("u9_3.done_gone", 64'(a_if.done), 64'd0);

        // Abort sampled at E10.
        a_if.start = 1'b1; a_if.is_signed = 1'b0;
        a_if.dividend = 32'd100; a_if.divisor = 32'd7;
        @(negedge clock);
        a_if.start = 1'b0;
        repeat (9) @(negedge clock);
        a_if.abort = 1'b1;
        @(negedge clock);
        a_if.abort = 1'b0;
        check_val("abort.busy", 64'(a_if.busy), 64'd0);
        seen_done = a_if.done;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            seen_done = seen_done | a_if.done;
        end
        check_val("abort.no_done", 64'(seen_done), 64'd0);
        check_val("abort.q_hold", 64'(a_if.quotient), 64'd3);
        check_val("abort.r_hold", 64'(a_if.remainder), 64'd0);
        run_a(1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 33, "u_ffff_16");

        // Asynchronous reset mid-CALC.
        a_if.start = 1'b1; a_if.is_signed = 1'b0;
        a_if.dividend = 32'd100; a_if.divisor = 32'd7;
        @(negedge clock);
        a_if.start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst.busy", 64'(a_if.busy), 64'd0);
        check_val("mid_rst.done", 64'(a_if.done), 64'd0);
        check_val("mid_rst.q", 64'(a_if.quotient), 64'd0);
        check_val("mid_rst.r", 64'(a_if.remainder), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("post_rst.busy", 64'(a_if.busy), 64'd0);
        run_a(1'b0, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 33, "u1_1");

        // Instance B: 2 bits per cycle, back-to-back, start ignored while busy.
        run_b(1'b0, 16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 9, 1'b1, "b_ffff_ff");
        run_b(1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 9, 1'b1, "b_1000_7");
        run_b(1'b1, 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 9, 1'b0, "b_sm100_7");
        repeat (3) @(negedge clock);
        check_val("b_idle.busy", 64'(b_if.busy), 64'd0);
        check_val("b_idle.q_hold", 64'(b_if.quotient), 64'hFFF2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
